// File: rtl/led_rate_decoder.sv
// Blink-rate decoder: measures the half-period of an asynchronous LED blink
// signal and locks onto one of four nominal rates after two agreeing measurements.
module led_rate_decoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        blink_in,
  output logic [1:0]  rate_code,
  output logic        rate_valid,
  output logic        rate_err,
  output logic [14:0] meas_period
);

  localparam logic [14:0] TOL     = 15'd2;
  localparam logic [14:0] TIMEOUT = 15'd25000;
  localparam logic [14:0] HALF [4] = '{15'd125, 15'd250, 15'd1250, 15'd12500};

  typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

  state_t      state, state_d;
  logic        s1, s2, s3;
  logic        blink_edge;
  logic [14:0] cnt, cnt_d, period;
  logic        match, match_d;
  logic [1:0]  cand, cand_d, code_d, win_code;
  logic        valid_d, err_d, in_win, timeout_hit;
  logic [14:0] meas_d;

  // s3 is history only; the edge is seen one flop after the synchroniser output
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= blink_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign blink_edge  = s2 ^ s3;
  // cnt was cleared at the previous edge, so the elapsed count is one ahead of it
  assign period      = (cnt == TIMEOUT) ? TIMEOUT : cnt + 15'd1;
  assign timeout_hit = !blink_edge && (cnt == TIMEOUT - 15'd1);

  always_comb begin
    in_win   = 1'b0;
    win_code = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (period >= HALF[k] - TOL && period <= HALF[k] + TOL) begin
        in_win   = 1'b1;
        win_code = k[1:0];
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = blink_edge ? 15'd0 : ((cnt == TIMEOUT) ? cnt : cnt + 15'd1);
    match_d = match;
    cand_d  = cand;
    code_d  = rate_code;
    valid_d = rate_valid;
    err_d   = 1'b0;
    meas_d  = meas_period;
    if (!enable) begin
      state_d = IDLE;
      match_d = 1'b0;
      cnt_d   = 15'd0;
      valid_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (blink_edge) begin
            state_d = SYNC;
            match_d = 1'b0;
          end
        end
        SYNC: begin
          if (blink_edge) begin
            meas_d = period;
            if (!in_win) begin
              err_d   = 1'b1;
              match_d = 1'b0;
            end else if (match && win_code == cand) begin
              state_d = LOCKED;
              code_d  = cand;
              valid_d = 1'b1;
            end else begin
              cand_d  = win_code;
              match_d = 1'b1;
            end
          end else if (timeout_hit) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        LOCKED: begin
          if (blink_edge) begin
            meas_d = period;
            if (!in_win) begin
              err_d   = 1'b1;
              state_d = SYNC;
              match_d = 1'b0;
              valid_d = 1'b0;
            end else if (win_code != cand) begin
              state_d = SYNC;
              cand_d  = win_code;
              match_d = 1'b1;
              valid_d = 1'b0;
            end
          end else if (timeout_hit) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= 15'd0;
      match       <= 1'b0;
      cand        <= 2'd0;
      rate_code   <= 2'd0;
      rate_valid  <= 1'b0;
      rate_err    <= 1'b0;
      meas_period <= 15'd0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      match       <= match_d;
      cand        <= cand_d;
      rate_code   <= code_d;
      rate_valid  <= valid_d;
      rate_err    <= err_d;
      meas_period <= meas_d;
    end
  end

endmodule

// File: tb/tb_led_rate_decoder.sv
// Directed bench for led_rate_decoder: timestamp-based reference model compared
// every cycle, plus hand-computed spot checks at key points.
module tb_led_rate_decoder;

  logic        clock, reset_n, enable, blink_in;
  logic [1:0]  rate_code;
  logic        rate_valid, rate_err;
  logic [14:0] meas_period;

  int total = 0;
  int bad   = 0;

  led_rate_decoder dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .blink_in(blink_in),
    .rate_code(rate_code), .rate_valid(rate_valid), .rate_err(rate_err),
    .meas_period(meas_period)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  localparam int TIMEOUT = 25000;
  int half_tab [4] = '{125, 250, 1250, 12500};

  // Reference model: edges are known by the cycle they take effect; the
  // half-period is simply the difference between edge timestamps.
  int        cyc = 0;
  int        q[$];
  int        last = 0;
  int        p, k;
  bit        ev;
  int        m_st;          // 0 idle, 1 sync, 2 locked
  bit        m_match, m_valid, m_err;
  logic [1:0]  m_cand, m_code;
  logic [14:0] m_meas;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_st = 0; m_match = 0; m_cand = 0; m_code = 0;
      m_valid = 0; m_err = 0; m_meas = 0;
    end else begin
      cyc++;
      ev = 0;
      if (q.size() > 0 && q[0] == cyc) begin
        ev = 1;
        void'(q.pop_front());
      end
      m_err = 0;
      if (!enable) begin
        m_st = 0; m_match = 0; m_valid = 0;
      end else if (m_st == 0) begin
        if (ev) begin
          m_st = 1; m_match = 0; last = cyc;
        end
      end else if (ev) begin
        p = cyc - last;
        if (p > TIMEOUT) p = TIMEOUT;
        last = cyc;
        m_meas = p[14:0];
        k = -1;
        for (int i = 0; i < 4; i++)
          if (p >= half_tab[i] - 2 && p <= half_tab[i] + 2) k = i;
        if (k < 0) begin
          m_err = 1; m_match = 0; m_st = 1; m_valid = 0;
        end else if (m_st == 2) begin
          if (k[1:0] != m_code) begin
            m_st = 1; m_cand = k[1:0]; m_match = 1; m_valid = 0;
          end
        end else if (m_match && k[1:0] == m_cand) begin
          m_st = 2; m_code = k[1:0]; m_valid = 1;
        end else begin
          m_cand = k[1:0]; m_match = 1;
        end
      end else if (cyc - last >= TIMEOUT) begin
        m_st = 0; m_valid = 0;
      end
    end
  end

  always @(negedge clock) begin
    total++;
    if (rate_code !== m_code || rate_valid !== m_valid || rate_err !== m_err ||
        meas_period !== m_meas) begin
      bad++;
      $display("FAIL model t=%0t code=%0d/%0d valid=%0d/%0d err=%0d/%0d meas=%0d/%0d (got/want)",
               $time, rate_code, m_code, rate_valid, m_valid, rate_err, m_err,
               meas_period, m_meas);
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // The change is captured by s1 next edge and takes effect three edges on.
  task automatic tog();
    blink_in = ~blink_in;
    q.push_back(cyc + 3);
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b1; blink_in = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    chk("rst_code", rate_code, 0);
    chk("rst_valid", rate_valid, 0);
    chk("rst_meas", meas_period, 0);
    step(3);
    reset_n = 1'b1;
    step(1);
    chk("post_rst_err", rate_err, 0);

    // lock at 125
    step(1); tog(); step(125); tog(); step(125); tog();
    step(2); chk("lock125_pre_valid", rate_valid, 0);
    step(1); chk("lock125_valid", rate_valid, 1);
    chk("lock125_code", rate_code, 0);
    chk("lock125_meas", meas_period, 125);

    // window bounds
    step(120); tog(); step(3);
    chk("p123_valid", rate_valid, 1); chk("p123_meas", meas_period, 123);
    step(124); tog(); step(3);
    chk("p127_valid", rate_valid, 1); chk("p127_meas", meas_period, 127);
    step(119); tog(); step(2); chk("p122_err_pre", rate_err, 0);
    step(1); chk("p122_err", rate_err, 1); chk("p122_valid", rate_valid, 0);
    chk("p122_meas", meas_period, 122);
    step(1); chk("p122_err_pulse", rate_err, 0);
    step(121); tog(); step(3); chk("relock_match_valid", rate_valid, 0);
    step(122); tog(); step(3); chk("relock_valid", rate_valid, 1);
    step(497); tog(); step(3);
    chk("p500_err", rate_err, 1); chk("p500_valid", rate_valid, 0);
    chk("p500_meas", meas_period, 500);

    // 250 -> 1250
    step(247); tog(); step(3);
    step(247); tog(); step(3);
    chk("lock250_valid", rate_valid, 1); chk("lock250_code", rate_code, 1);
    step(1247); tog(); step(3);
    chk("chg1250_valid", rate_valid, 0); chk("chg1250_code", rate_code, 1);
    step(1247); tog(); step(3);
    chk("lock1250_valid", rate_valid, 1); chk("lock1250_code", rate_code, 2);

    // asynchronous reset while locked at code 2
    step(10);
    #1 reset_n = 1'b0;
    blink_in = 1'b0;
    q.delete();
    #1;
    chk("arst_code", rate_code, 0); chk("arst_valid", rate_valid, 0);
    chk("arst_meas", meas_period, 0); chk("arst_err", rate_err, 0);
    step(3);
    reset_n = 1'b1;
    step(1);
    step(1); tog(); step(1250); tog(); step(1250); tog();
    step(2); chk("relock2_pre", rate_valid, 0);
    step(1); chk("relock2_valid", rate_valid, 1); chk("relock2_code", rate_code, 2);

    // enable low while locked
    step(5); enable = 1'b0;
    step(1);
    chk("dis_valid", rate_valid, 0); chk("dis_code", rate_code, 2);
    chk("dis_meas", meas_period, 1250);
    tog(); step(10);
    enable = 1'b1;
    step(1);

    // lock at 125 then freeze for timeout
    tog(); step(125); tog(); step(125); tog(); step(3);
    chk("to_lock_valid", rate_valid, 1); chk("to_lock_code", rate_code, 0);
    step(24999); chk("to_pre_valid", rate_valid, 1);
    step(1); chk("to_valid", rate_valid, 0); chk("to_err", rate_err, 0);
    chk("to_code_hold", rate_code, 0);

    // lock at 12500 from idle
    tog(); step(12500); tog(); step(12500); tog();
    step(2); chk("lock12500_pre", rate_valid, 0);
    step(1); chk("lock12500_valid", rate_valid, 1);
    chk("lock12500_code", rate_code, 3); chk("lock12500_meas", meas_period, 12500);

    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
